ahblite_decoder_mux: RTL and testbench
======================================

# ahblite_decoder_mux

Parametrised AHB-Lite address decoder with integrated slave-response multiplexer and built-in default slave. It sits between the Cortex-M0 master and up to 8 AHB-Lite slaves (RAMCODE, RAMDATA, peripherals, MicroCode controller/RAM). Each port's region is set by a base/mask pair rather than a hard-coded compare. The block registers the data-phase owner, drives HREADY/HRDATA/HRESP back to the master, and answers unmapped accesses with a protocol-correct two-cycle ERROR. It also captures the address and a count of decode faults.

## Interface
- NUM_PORTS, 7: number of slave ports, 1..8.
- PORT_EN, 7'b1100011: per-port enable; bit i = 0 forces P_HSEL[i] low and makes the region unmapped.
- BASE_ADDR, {0x40001000, 0x40000030, 0x40000020, 0x40000010, 0x40000000, 0x20000000, 0x00000000}: packed NUM_PORTS×32; port i base is bits [32i+31:32i].
- ADDR_MASK, {0xFFFFF000, 0xFFFFFFF0, 0xFFFFFFF0, 0xFFFFFFF0, 0xFFFFFFF0, 0xFFFF0000, 0xFFFF0000}: packed NUM_PORTS×32 compare masks.
- HCLK  in  1  bus clock.
- HRESET  in  1  asynchronous, active-high reset.
- HADDR  in  32  master address.
- HTRANS  in  2  master transfer type.
- P_HSEL  out  NUM_PORTS  one-hot slave select (address phase).
- P_HREADYOUT  in  NUM_PORTS  per-slave ready.
- P_HRESP  in  NUM_PORTS  per-slave response.
- P_HRDATA  in  NUM_PORTS×32  per-slave read data; port i uses [32i+31:32i].
- HREADY  out  1  muxed ready to the master and to all slaves.
- HRESP  out  1  muxed response.
- HRDATA  out  32  muxed read data.
- ERR_CNT  out  8  saturating count of default-slave ERROR responses.
- ERR_ADDR  out  32  HADDR of the most recent unmapped active transfer.

## Operation
- **Match.** Port i matches when `(HADDR & ADDR_MASK[i]) == BASE_ADDR[i]` and PORT_EN[i] = 1.
- **Overlap.** On overlapping regions, the lowest index wins. P_HSEL is always one-hot or all-zero.
- **Default select.** The default slave is selected when no port matches.
- **Data-phase owner.** Register `sel_q` is NUM_PORTS+1 bits, one-hot, with the top bit = default. It loads the address-phase select on every HCLK edge where HREADY = 1, and holds while HREADY = 0.
- **Response mux.** HREADY/HRESP/HRDATA come from the `sel_q` owner. When the default slave owns the data phase, HRDATA = 0.
- **Default slave FSM.** States IDLE, ERR1, ERR2.
  - IDLE → ERR1 when the default slave is selected, HTRANS[1] = 1 (NONSEQ/SEQ) and HREADY = 1.
  - ERR1 drives HREADY = 0, HRESP = 1, then goes to ERR2.
  - ERR2 drives HREADY = 1, HRESP = 1, then goes to ERR1 if a new qualifying unmapped transfer is presented, otherwise to IDLE.
  - IDLE/BUSY transfers to the default slave get a zero-wait OKAY (HREADY = 1, HRESP = 0).
- **ERR_ADDR** loads HADDR on each IDLE→ERR1 or ERR2→ERR1 transition.
- **ERR_CNT** increments on entry to ERR1 and saturates at 0xFF.
- **Reset values:**
  - `sel_q` = default.
  - FSM = IDLE.
  - HREADY = 1, HRESP = 0, HRDATA = 0.
  - ERR_CNT = 0, ERR_ADDR = 0.
  - P_HSEL follows HADDR combinationally, also during reset.

## Timing
- P_HSEL has zero latency (combinational from HADDR).
- The data-phase mux switches one cycle after the address phase is accepted (HREADY = 1 edge).
- A slave wait state (P_HREADYOUT = 0) propagates to HREADY in the same cycle and freezes `sel_q`.
- An unmapped active transfer produces exactly one wait cycle (ERR1) followed by one ERROR-complete cycle (ERR2).
- Back-to-back unmapped transfers give an ERR1, ERR2, ERR1, ERR2 sequence with no IDLE gap.
- Reset asserted mid-transfer (including during ERR1) immediately forces the reset values.
  - The first post-reset HREADY = 1 accepts a new address phase.

## Test plan
- Reset release, HADDR = 0x00000100, HTRANS = NONSEQ → P_HSEL = 0x01. Next cycle HRDATA = P_HRDATA[31:0] and HREADY = P_HREADYOUT[0].
- HADDR = 0x40000034 → P_HSEL[5] = 1. Slave 5 holds HREADYOUT = 0 for 3 cycles → HREADY low for 3 cycles and `sel_q` unchanged. A different address presented during the wait does not switch the mux.
- HADDR = 0x40000000 with PORT_EN[2] = 0 → P_HSEL = 0 and the transfer goes to the default slave.
  - Expect HREADY = 0/HRESP = 1, then HREADY = 1/HRESP = 1.
  - ERR_ADDR = 0x40000000, ERR_CNT = 1.
- HADDR = 0x50000000 with HTRANS = IDLE → no ERROR, HREADY = 1, HRESP = 0, ERR_CNT unchanged.
- 300 consecutive unmapped NONSEQ transfers → each gets an ERR1/ERR2 pair and ERR_CNT saturates at 0xFF.
- Assert HRESET during ERR1 → HREADY = 1, HRESP = 0 and ERR_CNT = 0 immediately, before the next HCLK edge.

Source files
------------

// File: rtl/ahblite_decoder_mux.sv
// AHB-Lite address decoder with data-phase response multiplexer and a built-in
// default slave that answers unmapped accesses with a two-cycle ERROR.
module ahblite_decoder_mux #(
  parameter int                       NUM_PORTS = 7,
  parameter logic [NUM_PORTS-1:0]     PORT_EN   = 7'b1100011,
  parameter logic [NUM_PORTS*32-1:0]  BASE_ADDR = {32'h4000_1000, 32'h4000_0030, 32'h4000_0020,
                                                   32'h4000_0010, 32'h4000_0000, 32'h2000_0000,
                                                   32'h0000_0000},
  parameter logic [NUM_PORTS*32-1:0]  ADDR_MASK = {32'hFFFF_F000, 32'hFFFF_FFF0, 32'hFFFF_FFF0,
                                                   32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_0000,
                                                   32'hFFFF_0000}
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [31:0]               HADDR,
  input  logic [1:0]                HTRANS,
  output logic [NUM_PORTS-1:0]      P_HSEL,
  input  logic [NUM_PORTS-1:0]      P_HREADYOUT,
  input  logic [NUM_PORTS-1:0]      P_HRESP,
  input  logic [NUM_PORTS*32-1:0]   P_HRDATA,
  output logic                      HREADY,
  output logic                      HRESP,
  output logic [31:0]               HRDATA,
  output logic [7:0]                ERR_CNT,
  output logic [31:0]               ERR_ADDR
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ERR1,
    ST_ERR2
  } def_state_e;

  def_state_e             def_state;
  logic                   def_hready_q;
  logic                   def_hresp_q;
  logic                   def_sel;
  logic                   err_start;
  logic [NUM_PORTS:0]     sel_q;

  // Address-phase decode; scanning from the top lets the lowest index win overlaps.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    P_HSEL  = '0;
    def_sel = 1'b1;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (PORT_EN[i] && ((HADDR & ADDR_MASK[32*i +: 32]) == BASE_ADDR[32*i +: 32])) begin
        P_HSEL    = '0;
        P_HSEL[i] = 1'b1;
        def_sel   = 1'b0;
      end
    end
  end

  // Data-phase owner; top bit is the default slave.
  always_ff @(posedge HCLK or posedge HRESET) begin
    // NOTE: sequential state is updated only with non-blocking assignments.
    if (HRESET) begin
      sel_q <= {1'b1, {NUM_PORTS{1'b0}}};
    end else if (HREADY) begin
      sel_q <= {def_sel, P_HSEL};
    end
  end

  // Response mux driven by the registered owner; the default slave returns zero data.
  always_comb begin
    HREADY = def_hready_q;
    HRESP  = def_hresp_q;
    HRDATA = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel_q[i]) begin
        HREADY = P_HREADYOUT[i];
        HRESP  = P_HRESP[i];
        HRDATA = P_HRDATA[32*i +: 32];
      end
    end
  end

  assign err_start = def_sel && (HTRANS inside {2'b10, 2'b11}) && HREADY;

  // Default slave: one wait cycle with ERROR, then one ERROR-complete cycle.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      def_state    <= ST_IDLE;
      def_hready_q <= 1'b1;
      def_hresp_q  <= 1'b0;
      ERR_CNT      <= 8'd0;
      ERR_ADDR     <= 32'd0;
    end else begin
      case (def_state)
        ST_ERR1: begin
          def_state    <= ST_ERR2;
          def_hready_q <= 1'b1;
          def_hresp_q  <= 1'b1;
        end
        ST_IDLE, ST_ERR2: begin
          if (err_start) begin
            def_state    <= ST_ERR1;
            def_hready_q <= 1'b0;
            def_hresp_q  <= 1'b1;
            ERR_ADDR     <= HADDR;
            if (ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
          end else begin
            def_state    <= ST_IDLE;
            def_hready_q <= 1'b1;
            def_hresp_q  <= 1'b0;
          end
        end
        default: begin
          def_state    <= ST_IDLE;
          def_hready_q <= 1'b1;
          def_hresp_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahblite_decoder_mux.sv
// Randomised bench for ahblite_decoder_mux against a transaction-level model of
// region decode, data-phase ownership and the default slave's error sequence.
module tb_ahblite_decoder_mux;

  localparam int NP = 7;
  localparam logic [NP-1:0] EN = 7'b1100011;

  logic [31:0] base_tab [NP] = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000, 32'h4000_0010,
                                 32'h4000_0020, 32'h4000_0030, 32'h4000_1000};
  logic [31:0] mask_tab [NP] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_FFF0,
                                 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_F000};

  logic            HCLK = 1'b0;
  logic            HRESET;
  logic [31:0]     HADDR;
  logic [1:0]      HTRANS;
  logic [NP-1:0]   P_HSEL;
  logic [NP-1:0]   P_HREADYOUT;
  logic [NP-1:0]   P_HRESP;
  logic [NP*32-1:0] P_HRDATA;
  logic            HREADY;
  logic            HRESP;
  logic [31:0]     HRDATA;
  logic [7:0]      ERR_CNT;
  logic [31:0]     ERR_ADDR;

  ahblite_decoder_mux dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .P_HSEL      (P_HSEL),
    .P_HREADYOUT (P_HREADYOUT),
    .P_HRESP     (P_HRESP),
    .P_HRDATA    (P_HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .HRDATA      (HRDATA),
    .ERR_CNT     (ERR_CNT),
    .ERR_ADDR    (ERR_ADDR)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: owner of the data phase (-1 = default slave), error phase
  // (0 = none, 1 = wait cycle, 2 = error-complete cycle), fault log.
  int          m_owner;
  int          m_phase;
  int          m_cnt;
  logic [31:0] m_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NP; i++)
      if (EN[i] && ((a & mask_tab[i]) == base_tab[i])) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_phase = 0;
    m_cnt   = 0;
    m_addr  = 32'd0;
  endtask

  // Called at a falling edge with inputs applied; checks, then advances one clock.
  task automatic cycle();
    int          dec;
    int          n_owner, n_phase;
    logic        e_rdy, e_resp;
    logic [31:0] e_data, e_sel;
    #1;
    dec   = decode(HADDR);
    e_sel = (dec < 0) ? 32'd0 : (32'd1 << dec);
    if (m_owner < 0) begin
      e_rdy  = (m_phase != 1);
      e_resp = (m_phase != 0);
      e_data = 32'd0;
    end else begin
      e_rdy  = P_HREADYOUT[m_owner];
      e_resp = P_HRESP[m_owner];
      e_data = P_HRDATA[32*m_owner +: 32];
    end
    check("p_hsel",   {25'd0, P_HSEL}, e_sel);
    check("hready",   {31'd0, HREADY}, {31'd0, e_rdy});
    check("hresp",    {31'd0, HRESP},  {31'd0, e_resp});
    check("hrdata",   HRDATA, e_data);
    check("err_cnt",  {24'd0, ERR_CNT}, 32'(m_cnt));
    check("err_addr", ERR_ADDR, m_addr);
    n_owner = e_rdy ? dec : m_owner;
    if (e_rdy && dec < 0 && HTRANS[1]) begin
      n_phase = 1;
      if (m_cnt < 255) m_cnt++;
      m_addr = HADDR;
    end else if (m_phase == 1) begin
      n_phase = 2;
    end else begin
      n_phase = 0;
    end
    @(posedge HCLK);
    m_owner = n_owner;
    m_phase = n_phase;
    @(negedge HCLK);
  endtask

  task automatic rand_inputs();
    case ($urandom_range(0, 6))
      0: HADDR = {16'h0000, 16'($urandom)};
      1: HADDR = {16'h2000, 16'($urandom)};
      2: HADDR = 32'h4000_0030 + 32'($urandom_range(0, 15));
      3: HADDR = 32'h4000_1000 + 32'($urandom_range(0, 4095));
      4: HADDR = 32'h4000_0000 + 32'($urandom_range(0, 47));
      5: HADDR = 32'h5000_0000;
      default: HADDR = $urandom;
    endcase
    HTRANS = 2'($urandom_range(0, 3));
    for (int i = 0; i < NP; i++) begin
      P_HREADYOUT[i]    = ($urandom_range(0, 3) != 0);
      P_HRESP[i]        = ($urandom_range(0, 7) == 0);
      P_HRDATA[32*i +: 32] = $urandom;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    HRESET      = 1'b1;
    HADDR       = 32'h0000_0100;
    HTRANS      = 2'b10;
    P_HREADYOUT = '1;
    P_HRESP     = '0;
    for (int i = 0; i < NP; i++) P_HRDATA[32*i +: 32] = 32'hA000_0000 + 32'(i);
    model_reset();

    // Reset values, with P_HSEL following HADDR during reset.
    #2;
    check("rst_hsel",    {25'd0, P_HSEL}, 32'h1);
    check("rst_hready",  {31'd0, HREADY}, 32'd1);
    check("rst_hresp",   {31'd0, HRESP},  32'd0);
    check("rst_hrdata",  HRDATA, 32'd0);
    check("rst_err_cnt", {24'd0, ERR_CNT}, 32'd0);
    check("rst_err_addr", ERR_ADDR, 32'd0);
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;

    // Port 0 transfer, then its data phase.
    cycle();
    HTRANS = 2'b00;
    HADDR  = 32'h0000_0000;
    cycle();

    // Port 5 with three slave wait states; the new address must not move the mux.
    HADDR  = 32'h4000_0034;
    HTRANS = 2'b10;
    cycle();
    HADDR  = 32'h0000_0100;
    P_HREADYOUT[5] = 1'b0;
    repeat (3) cycle();
    P_HREADYOUT[5] = 1'b1;
    cycle();

    // Disabled region gets the two-cycle ERROR.
    HADDR  = 32'h4000_0000;
    HTRANS = 2'b10;
    cycle();
    HTRANS = 2'b00;
    HADDR  = 32'h0000_0000;
    cycle();
    cycle();
    check("err_addr_disabled", ERR_ADDR, 32'h4000_0000);
    check("err_cnt_disabled", {24'd0, ERR_CNT}, 32'd1);

    // IDLE transfer to an unmapped address is a zero-wait OKAY.
    HADDR  = 32'h5000_0000;
    HTRANS = 2'b00;
    repeat (3) cycle();

    // Randomised traffic.
    for (int n = 0; n < 2000; n++) begin
      rand_inputs();
      cycle();
    end

    // Reset asserted while the default slave is in its wait cycle.
    HADDR       = 32'h5000_0000;
    HTRANS      = 2'b10;
    P_HREADYOUT = '1;
    guard = 0;
    while (m_phase != 1 && guard < 8) begin
      cycle();
      guard++;
    end
    check("reach_err1", 32'(m_phase), 32'd1);
    #1;
    check("err1_hready", {31'd0, HREADY}, 32'd0);
    HRESET = 1'b1;
    #1;
    check("mid_rst_hready", {31'd0, HREADY}, 32'd1);
    check("mid_rst_hresp",  {31'd0, HRESP},  32'd0);
    check("mid_rst_err_cnt", {24'd0, ERR_CNT}, 32'd0);
    check("mid_rst_hrdata", HRDATA, 32'd0);
    model_reset();
    @(negedge HCLK);
    HRESET = 1'b0;
    HADDR  = 32'h0000_0100;
    HTRANS = 2'b10;
    cycle();
    HTRANS = 2'b00;
    cycle();

    // 300 back-to-back unmapped NONSEQ transfers saturate the counter.
    HADDR  = 32'h5000_0000;
    HTRANS = 2'b10;
    for (int n = 0; n < 600; n++) cycle();
    check("err_cnt_saturated", {24'd0, ERR_CNT}, 32'h0000_00FF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
